// File: rtl/fpu_resp_buffer.sv
// fpu_resp_buffer
//   Credit-based response buffer between an interconnect and an FPU wrapper.
//   A request is forwarded to the FPU only while a FIFO slot can be
//   guaranteed for its response (in-flight + stored < DEPTH). This matters
//   because the FPU response path cannot be backpressured. Responses are
//   stored in push order and presented to the consumer through a
//   valid/ready handshake.
//
// Ports
//   clk, rst_n          : clock, synchronous active-low reset
//   req_i / gnt_o       : interconnect request / grant
//   fpu_req_o/fpu_gnt_i : request to / grant from the FPU wrapper
//   fpu_r*_i            : FPU response (valid, data, flags, tag)
//   resp_*_o            : buffered response (valid, data, flags, tag)
//   resp_ready_i        : consumer ready
//   reserved_o          : in-flight plus stored response count
//   err_o               : sticky protocol error (overflow or stray response)
module fpu_resp_buffer #(
  parameter int ID_WIDTH        = 9,
  parameter int DATA_WIDTH      = 32,
  parameter int FLAGS_OUT_WIDTH = 5,
  parameter int DEPTH           = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_i,
  output logic                         gnt_o,
  output logic                         fpu_req_o,
  input  logic                         fpu_gnt_i,
  input  logic                         fpu_rvalid_i,
  input  logic [DATA_WIDTH-1:0]        fpu_rdata_i,
  input  logic [FLAGS_OUT_WIDTH-1:0]   fpu_rflags_i,
  input  logic [ID_WIDTH-1:0]          fpu_rID_i,
  output logic                         resp_valid_o,
  output logic [DATA_WIDTH-1:0]        resp_data_o,
  output logic [FLAGS_OUT_WIDTH-1:0]   resp_flags_o,
  output logic [ID_WIDTH-1:0]          resp_ID_o,
  input  logic                         resp_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   reserved_o,
  output logic                         err_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = DATA_WIDTH + FLAGS_OUT_WIDTH + ID_WIDTH;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic [CNT_W-1:0] reserved_q, reserved_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic             err_q, err_d;

  logic credit_ok;
  logic issue;
  logic pop;
  logic push;
  logic full;
  logic push_acc;
  logic no_inflight;
  logic res_dec;

  // Credit check uses only registered state, so resp_ready_i never reaches
  // fpu_req_o/gnt_o combinationally; a pop frees its slot one cycle later.
  always_comb begin
    credit_ok    = (reserved_q < DEPTH_C);
    fpu_req_o    = req_i & credit_ok;
    gnt_o        = fpu_gnt_i & credit_ok;
    issue        = fpu_req_o & fpu_gnt_i;
    resp_valid_o = (cnt_q != '0);
    pop          = resp_valid_o & resp_ready_i;
    push         = fpu_rvalid_i;
    full         = (cnt_q == DEPTH_C);
    // A full FIFO still takes a push when a pop drains a slot that cycle.
    push_acc     = push & (~full | pop);
    // No response outstanding: stored entries already cover every credit.
    // Written as a compare so a stored stray response cannot wrap it.
    no_inflight  = (reserved_q <= cnt_q);
    // Pops of stray (uncredited) entries must not underflow the counter.
    res_dec      = pop & ((reserved_q != '0) | issue);
  end

  always_comb begin
    reserved_d = reserved_q;
    cnt_d      = cnt_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    err_d      = err_q;

    case ({issue, res_dec})
      2'b10:   reserved_d = reserved_q + CNT_W'(1);
      2'b01:   reserved_d = reserved_q - CNT_W'(1);
      default: reserved_d = reserved_q;
    endcase

    case ({push_acc, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    if (push_acc) wptr_d = wptr_q + PTR_W'(1);
    if (pop)      rptr_d = rptr_q + PTR_W'(1);

    if (push & ~push_acc)   err_d = 1'b1;
    if (push & no_inflight) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reserved_q <= '0;
      cnt_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      reserved_q <= reserved_d;
      cnt_q      <= cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      err_q      <= err_d;
    end
  end

  // Storage is never reset; resp_valid_o masks stale contents.
  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wptr_q] <= {fpu_rdata_i, fpu_rflags_i, fpu_rID_i};
  end

  assign {resp_data_o, resp_flags_o, resp_ID_o} = mem_q[rptr_q];
  assign reserved_o = reserved_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_fpu_resp_buffer.sv
module tb_fpu_resp_buffer;

  localparam int IDW = 9;
  localparam int DW  = 32;
  localparam int FW  = 5;
  localparam int DEP = 4;
  localparam int RW  = $clog2(DEP + 1);

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req_i, gnt_o, fpu_req_o, fpu_gnt_i;
  logic           fpu_rvalid_i;
  logic [DW-1:0]  fpu_rdata_i;
  logic [FW-1:0]  fpu_rflags_i;
  logic [IDW-1:0] fpu_rID_i;
  logic           resp_valid_o;
  logic [DW-1:0]  resp_data_o;
  logic [FW-1:0]  resp_flags_o;
  logic [IDW-1:0] resp_ID_o;
  logic           resp_ready_i;
  logic [RW-1:0]  reserved_o;
  logic           err_o;

  always #5 clk = ~clk;

  fpu_resp_buffer #(
    .ID_WIDTH(IDW), .DATA_WIDTH(DW), .FLAGS_OUT_WIDTH(FW), .DEPTH(DEP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_i(req_i), .gnt_o(gnt_o),
    .fpu_req_o(fpu_req_o), .fpu_gnt_i(fpu_gnt_i),
    .fpu_rvalid_i(fpu_rvalid_i), .fpu_rdata_i(fpu_rdata_i),
    .fpu_rflags_i(fpu_rflags_i), .fpu_rID_i(fpu_rID_i),
    .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o),
    .resp_flags_o(resp_flags_o), .resp_ID_o(resp_ID_o),
    .resp_ready_i(resp_ready_i),
    .reserved_o(reserved_o), .err_o(err_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [DW-1:0]  data;
    logic [FW-1:0]  flags;
    logic [IDW-1:0] id;
  } resp_t;

  resp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FW-1:0] flags_of(input logic [IDW-1:0] id);
    return id[FW-1:0] ^ 5'h15;
  endfunction

  // Drive one FPU response; stored responses are expected at the output.
  task automatic drive_resp(input logic [DW-1:0] d, input logic [IDW-1:0] id, input bit expect_out);
    resp_t r;
    fpu_rvalid_i = 1'b1;
    fpu_rdata_i  = d;
    fpu_rID_i    = id;
    fpu_rflags_i = flags_of(id);
    if (expect_out) begin
      r.data = d; r.flags = flags_of(id); r.id = id;
      sb.push_back(r);
    end
  endtask

  // Output monitor: scoreboard compare on each pop, hold-stability, bounds.
  logic           hold_q = 1'b0;
  logic [DW-1:0]  hold_data;
  logic [FW-1:0]  hold_flags;
  logic [IDW-1:0] hold_id;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_q = 1'b0;
    end else begin
      check("reserved_le_depth", 64'(reserved_o <= RW'(DEP)), 64'd1);
      if (!err_o) check("cnt_le_reserved", 64'(dut.cnt_q <= reserved_o), 64'd1);
      if (hold_q && resp_valid_o) begin
        check("hold_data", 64'(resp_data_o), 64'(hold_data));
        check("hold_id", 64'(resp_ID_o), 64'(hold_id));
        check("hold_flags", 64'(resp_flags_o), 64'(hold_flags));
      end
      hold_q     = resp_valid_o && !resp_ready_i;
      hold_data  = resp_data_o;
      hold_flags = resp_flags_o;
      hold_id    = resp_ID_o;
      if (resp_valid_o && resp_ready_i) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_pop_id", 64'(resp_ID_o), 64'h1_0000);
        end else begin
          resp_t e;
          e = sb.pop_front();
          check("resp_data", 64'(resp_data_o), 64'(e.data));
          check("resp_id", 64'(resp_ID_o), 64'(e.id));
          check("resp_flags", 64'(resp_flags_o), 64'(e.flags));
        end
      end
    end
  end

  typedef struct {
    logic           req, gnt, rvalid, ready;
    logic [DW-1:0]  data;
    logic [IDW-1:0] id;
    logic           e_freq, e_gnt, e_valid, e_err;
    logic [RW-1:0]  e_res;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  next_id;
    int  due[$];
    int  idq[$];
    bit  done;

    // Single op, then credit exhaustion with the consumer stalled.
    //          req gnt rv rdy data          id    freq gnt val err res
    tbl[0]  = '{1, 1, 0, 0, 32'h0,        9'd0, 1, 1, 0, 0, 3'd0};
    tbl[1]  = '{0, 0, 0, 0, 32'h0,        9'd0, 0, 0, 0, 0, 3'd1};
    tbl[2]  = '{0, 0, 0, 0, 32'h0,        9'd0, 0, 0, 0, 0, 3'd1};
    tbl[3]  = '{0, 0, 1, 0, 32'h3F800000, 9'd5, 0, 0, 0, 0, 3'd1};
    tbl[4]  = '{0, 0, 0, 0, 32'h0,        9'd0, 0, 0, 1, 0, 3'd1};
    tbl[5]  = '{0, 0, 0, 1, 32'h0,        9'd0, 0, 0, 1, 0, 3'd1};
    tbl[6]  = '{0, 0, 0, 0, 32'h0,        9'd0, 0, 0, 0, 0, 3'd0};
    tbl[7]  = '{1, 1, 0, 0, 32'h0,        9'd0, 1, 1, 0, 0, 3'd0};
    tbl[8]  = '{1, 1, 0, 0, 32'h0,        9'd0, 1, 1, 0, 0, 3'd1};
    tbl[9]  = '{1, 1, 0, 0, 32'h0,        9'd0, 1, 1, 0, 0, 3'd2};
    tbl[10] = '{1, 1, 0, 0, 32'h0,        9'd0, 1, 1, 0, 0, 3'd3};
    tbl[11] = '{1, 1, 0, 0, 32'h0,        9'd0, 0, 0, 0, 0, 3'd4};
    tbl[12] = '{1, 1, 0, 0, 32'h0,        9'd0, 0, 0, 0, 0, 3'd4};

    rst_n = 1'b0; req_i = 1'b0; fpu_gnt_i = 1'b0; resp_ready_i = 1'b0;
    fpu_rvalid_i = 1'b0; fpu_rdata_i = '0; fpu_rflags_i = '0; fpu_rID_i = '0;
    tick(); tick();
    check("rst_reserved", 64'(reserved_o), 64'd0);
    check("rst_valid", 64'(resp_valid_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_fpu_req", 64'(fpu_req_o), 64'd0);
    check("rst_gnt", 64'(gnt_o), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      tick();
      req_i = tbl[i].req; fpu_gnt_i = tbl[i].gnt; resp_ready_i = tbl[i].ready;
      fpu_rvalid_i = 1'b0;
      if (tbl[i].rvalid) drive_resp(tbl[i].data, tbl[i].id, 1'b1);
      #1;
      check($sformatf("vec%0d_fpu_req", i), 64'(fpu_req_o), 64'(tbl[i].e_freq));
      check($sformatf("vec%0d_gnt", i), 64'(gnt_o), 64'(tbl[i].e_gnt));
      check($sformatf("vec%0d_valid", i), 64'(resp_valid_o), 64'(tbl[i].e_valid));
      check($sformatf("vec%0d_err", i), 64'(err_o), 64'(tbl[i].e_err));
      check($sformatf("vec%0d_reserved", i), 64'(reserved_o), 64'(tbl[i].e_res));
    end

    // Fill the FIFO with the 4 outstanding responses.
    for (int k = 0; k < 4; k++) begin
      tick();
      req_i = 1'b0; fpu_gnt_i = 1'b0;
      drive_resp(32'h1000 + DW'(k), IDW'(10 + k), 1'b1);
    end
    // Pop while full: slot is not reusable in the same cycle.
    tick();
    fpu_rvalid_i = 1'b0; req_i = 1'b1; fpu_gnt_i = 1'b1; resp_ready_i = 1'b1;
    #1;
    check("full_pop_fpu_req", 64'(fpu_req_o), 64'd0);
    check("full_pop_gnt", 64'(gnt_o), 64'd0);
    check("full_pop_reserved", 64'(reserved_o), 64'd4);
    check("full_pop_valid", 64'(resp_valid_o), 64'd1);
    tick();
    resp_ready_i = 1'b0;
    #1;
    check("after_pop_reserved", 64'(reserved_o), 64'd3);
    check("after_pop_fpu_req", 64'(fpu_req_o), 64'd1);
    check("after_pop_gnt", 64'(gnt_o), 64'd1);
    tick();
    req_i = 1'b0; fpu_gnt_i = 1'b0;
    #1;
    check("fifth_issue_reserved", 64'(reserved_o), 64'd4);
    tick();
    drive_resp(32'h1004, 9'd14, 1'b1);
    done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      fpu_rvalid_i = 1'b0; resp_ready_i = 1'b1;
      #1;
      if (!resp_valid_o && k > 0) begin done = 1'b1; break; end
    end
    resp_ready_i = 1'b0;
    check("drain_done", 64'(done), 64'd1);
    check("drain_reserved", 64'(reserved_o), 64'd0);
    check("drain_err", 64'(err_o), 64'd0);

    // Back-to-back ops with a 3-cycle FPU and a toggling consumer.
    next_id = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      tick();
      if (next_id == 10 && due.size() == 0 && !resp_valid_o) begin done = 1'b1; break; end
      resp_ready_i = (cyc % 2) == 1;
      fpu_rvalid_i = 1'b0;
      if (due.size() != 0 && due[0] == cyc) begin
        int id;
        void'(due.pop_front());
        id = idq.pop_front();
        drive_resp(32'h4000_0000 + DW'(id), IDW'(id), 1'b1);
      end
      req_i = (next_id < 10);
      fpu_gnt_i = req_i;
      #1;
      if (fpu_req_o && fpu_gnt_i) begin
        due.push_back(cyc + 3);
        idq.push_back(next_id);
        next_id++;
      end
    end
    req_i = 1'b0; fpu_gnt_i = 1'b0; resp_ready_i = 1'b0; fpu_rvalid_i = 1'b0;
    check("wrap_done", 64'(done), 64'd1);
    check("wrap_issued", 64'(next_id), 64'd10);
    check("wrap_err", 64'(err_o), 64'd0);
    check("wrap_reserved", 64'(reserved_o), 64'd0);

    // Stray response with nothing in flight.
    tick();
    drive_resp(32'hDEADBEEF, 9'h1FF, 1'b1);
    #1;
    check("stray_err_before", 64'(err_o), 64'd0);
    tick();
    fpu_rvalid_i = 1'b0;
    #1;
    check("stray_err", 64'(err_o), 64'd1);
    check("stray_valid", 64'(resp_valid_o), 64'd1);
    tick();
    resp_ready_i = 1'b1;
    tick();
    resp_ready_i = 1'b0;
    #1;
    check("stray_reserved", 64'(reserved_o), 64'd0);
    check("stray_valid_after", 64'(resp_valid_o), 64'd0);
    repeat (3) tick();
    check("stray_err_sticky", 64'(err_o), 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("stray_err_cleared", 64'(err_o), 64'd0);

    // Reset with 2 stored and 1 in flight.
    for (int k = 0; k < 3; k++) begin
      tick();
      req_i = 1'b1; fpu_gnt_i = 1'b1;
    end
    tick();
    req_i = 1'b0; fpu_gnt_i = 1'b0;
    drive_resp(32'h2000, 9'd20, 1'b0);
    tick();
    drive_resp(32'h2001, 9'd21, 1'b0);
    tick();
    fpu_rvalid_i = 1'b0;
    #1;
    check("mid_reserved", 64'(reserved_o), 64'd3);
    check("mid_valid", 64'(resp_valid_o), 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("mid_rst_reserved", 64'(reserved_o), 64'd0);
    check("mid_rst_valid", 64'(resp_valid_o), 64'd0);
    check("mid_rst_err", 64'(err_o), 64'd0);
    check("mid_rst_fpu_req", 64'(fpu_req_o), 64'd0);
    check("mid_rst_gnt", 64'(gnt_o), 64'd0);
    tick();
    drive_resp(32'h2002, 9'd22, 1'b1);
    tick();
    fpu_rvalid_i = 1'b0;
    #1;
    check("late_err", 64'(err_o), 64'd1);
    check("late_valid", 64'(resp_valid_o), 64'd1);
    tick();
    resp_ready_i = 1'b1;
    tick();
    resp_ready_i = 1'b0;
    #1;
    check("late_valid_after", 64'(resp_valid_o), 64'd0);
    tick();
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
